relu_column_scheduler: RTL and testbench
========================================

# relu_column_scheduler

Shares one ReLU column datapath between NUM_CH convolution output channels. Each channel presents one COLUMN_SIZE-wide column of signed 16-bit conv results at a time; the scheduler grants channels round-robin, applies ReLU to the granted column, and registers the result with its channel ID and column index. It sits between the conv engine channel outputs and the pooling/writeback stage.

## Interface
- COLUMN_SIZE, 24, elements per column
- NUM_CH, 4, number of requesting channels (≥2)
- COLS_PER_MAP, 24, columns per feature map per channel
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  [NUM_CH]  channel c has a column pending
- in_ready  out  [NUM_CH]  one-hot grant; transfer on in_valid[c] & in_ready[c]
- in_col  in  [NUM_CH][COLUMN_SIZE] x signed 16  per-channel column data
- out_valid  out  1  output register holds a column
- out_ready  in  1  downstream accepts
- out_col  out  [COLUMN_SIZE] x signed 16  ReLU'd column
- out_ch  out  $clog2(NUM_CH)  source channel of out_col
- out_col_idx  out  $clog2(COLS_PER_MAP)  column index within that channel's map
- out_last  out  1  out_col_idx == COLS_PER_MAP-1
- map_done  out  1  one-cycle pulse when every channel's last column has been accepted downstream

## Operation
- Output register is "free" when !out_valid or (out_valid & out_ready).
- When free, arbiter grants one requesting channel: first c with in_valid[c] searching from rr_ptr upward, wrapping. in_ready is one-hot on that channel, else all zero. in_ready is 0 for every channel when not free.
- On transfer from channel c: out_col <= ReLU(in_col[c]) per element (x<0 → 0, else x; −32768 → 0); out_ch <= c; out_col_idx <= col_cnt[c]; out_last <= (col_cnt[c]==COLS_PER_MAP-1); out_valid <= 1; rr_ptr <= (c+1) mod NUM_CH; col_cnt[c] increments, wrapping to 0 after COLS_PER_MAP-1.
- Free but no request: out_valid <= 0 (if it was accepted); other outputs hold.
- Stall (out_valid & !out_ready): all out_* hold stable; no grant.
- done_mask[NUM_CH] sets bit out_ch when an out_last column is accepted downstream. When the mask would become all-ones, map_done pulses that cycle and the mask clears.
- rr_ptr advances only on a transfer.

## Timing
- Reset values: out_valid 0, out_col all 0, out_ch 0, out_col_idx 0, out_last 0, map_done 0, in_ready 0; rr_ptr 0, all col_cnt 0, done_mask 0.
- Latency: input transfer in cycle N → out_valid in cycle N+1.
- Throughput: one column per cycle when out_ready is held high (accept and refill in the same cycle).
- in_ready is combinational from in_valid, out_valid, out_ready and rr_ptr. It has no dependence on in_col.
- Reset asserted mid-frame discards the held column and all counters. There is no partial-map recovery.
- Simultaneous events: a last-column accept plus a new grant in the same cycle are both processed. map_done is based on the accepted column only.

## Structure
- Package relu_sched_pkg: data_t (logic signed [15:0]), CH_W / IDX_W localparam helpers.
- Sub-module: the existing ReLU_column, instantiated once and fed by the grant mux; its outputs feed out_col register.
- Arbiter can be inline (fixed-priority search over rotated request vector).

## Test plan
- Reset then single request: in_valid=0001, in_col[0] = {−5, 0, 7, −32768, 32767, …} → in_ready=0001 same cycle; next cycle out_valid=1, out_col={0,0,7,0,32767,…}, out_ch=0, out_col_idx=0.
- All four channels valid, out_ready=1 continuously → grants 0,1,2,3,0,… one per cycle; out_ch sequence matches, each channel's out_col_idx increments separately.
- Backpressure: out_ready=0 for 5 cycles with a column held → out_* unchanged, in_ready=0000. On release, next grant goes to channel rr_ptr.
- Sparse requests: only channels 1 and 3 valid, rr_ptr=2 → grant 3, then 1, then 3.
- Full map: 4 channels × 24 columns with random out_ready stalls → out_last on idx 23 per channel, exactly one map_done pulse on the 96th accept, counters back to 0.
- Reset asserted while out_valid=1 and col_cnt[2]=10 → out_valid 0 immediately (async). After release, channel 2 restarts at out_col_idx=0.

Source files
------------

// File: rtl/relu_sched_pkg.sv
// Shared types and width helpers for the ReLU column scheduler.
package relu_sched_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  // Index width with a floor of one bit so single-entry ranges still get a port.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_COLUMN_SIZE  = 24;
  localparam int DEF_COLS_PER_MAP = 24;
  localparam int CH_W             = width_of(DEF_NUM_CH);
  localparam int IDX_W            = width_of(DEF_COLS_PER_MAP);

endpackage

// File: rtl/relu_column_scheduler_relu.sv
// Element-wise ReLU over one column of signed conv results; purely combinational.
module relu_column
  import relu_sched_pkg::*;
#(
  parameter int COLUMN_SIZE = DEF_COLUMN_SIZE
) (
  input  logic [COLUMN_SIZE-1:0][DATA_W-1:0] col_in,
  output logic [COLUMN_SIZE-1:0][DATA_W-1:0] col_out
);

  for (genvar i = 0; i < COLUMN_SIZE; i++) begin : g_elem
    data_t x;
    assign x          = data_t'(col_in[i]);
    assign col_out[i] = (x < 0) ? '0 : col_in[i];
  end

endmodule

// File: rtl/relu_column_scheduler.sv
// Round-robin scheduler sharing one ReLU column datapath between conv channels,
// with per-channel column counters and a whole-map completion pulse.
module relu_column_scheduler
  import relu_sched_pkg::*;
#(
  parameter int COLUMN_SIZE  = DEF_COLUMN_SIZE,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int COLS_PER_MAP = DEF_COLS_PER_MAP,
  localparam int CH_BITS     = width_of(NUM_CH),
  localparam int IDX_BITS    = width_of(COLS_PER_MAP)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_CH-1:0]                              in_valid,
  output logic [NUM_CH-1:0]                              in_ready,
  input  logic [NUM_CH-1:0][COLUMN_SIZE-1:0][DATA_W-1:0] in_col,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [COLUMN_SIZE-1:0][DATA_W-1:0]             out_col,
  output logic [CH_BITS-1:0]                             out_ch,
  output logic [IDX_BITS-1:0]                            out_col_idx,
  output logic                                           out_last,
  output logic                                           map_done
);

  logic [CH_BITS-1:0]               rr_ptr;
  logic [NUM_CH-1:0][IDX_BITS-1:0]  col_cnt;
  logic [NUM_CH-1:0]                done_mask;

  logic                             free;
  logic                             accept;
  logic                             grant_any;
  logic [CH_BITS-1:0]               grant_ch;
  logic                             fire;
  logic                             grant_last;
  logic [NUM_CH-1:0]                mask_nxt;
  logic                             mask_full;
  logic [COLUMN_SIZE-1:0][DATA_W-1:0] relu_col;

  assign accept = out_valid & out_ready;
  assign free   = ~out_valid | out_ready;

  // First requester at or after rr_ptr, wrapping around the channel ring.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        grant_ch  = CH_BITS'(idx);
      end
    end
  end

  assign fire = free & grant_any;

  always_comb begin
    in_ready = '0;
    if (fire) in_ready[grant_ch] = 1'b1;
  end

  relu_column #(
    .COLUMN_SIZE(COLUMN_SIZE)
  ) u_relu (
    .col_in (in_col[grant_ch]),
    .col_out(relu_col)
  );

  assign grant_last = (col_cnt[grant_ch] == IDX_BITS'(COLS_PER_MAP - 1));

  // Completion is judged on the column leaving downstream, not on new grants.
  assign mask_nxt  = done_mask | (NUM_CH'(1) << out_ch);
  assign mask_full = &mask_nxt;
  assign map_done  = accept & out_last & mask_full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: col_cnt is a handful of small counters that must restart at zero, so
  // it is reset along with the control state rather than left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_col     <= '0;
      out_ch      <= '0;
      out_col_idx <= '0;
      out_last    <= 1'b0;
      rr_ptr      <= '0;
      col_cnt     <= '0;
      done_mask   <= '0;
    end else begin
      if (free) out_valid <= fire;
      if (fire) begin
        out_col           <= relu_col;
        out_ch            <= grant_ch;
        out_col_idx       <= col_cnt[grant_ch];
        out_last          <= grant_last;
        rr_ptr            <= (grant_ch == CH_BITS'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        col_cnt[grant_ch] <= grant_last ? '0 : col_cnt[grant_ch] + 1'b1;
      end
      if (accept && out_last) done_mask <= mask_full ? '0 : mask_nxt;
    end
  end

endmodule

// File: tb/tb_relu_column_scheduler.sv
// Directed bench for relu_column_scheduler: vector table plus reset, full-map
// and mid-frame reset sequences.
module tb_relu_column_scheduler;

  localparam int NCH  = 4;
  localparam int CSZ  = 24;
  localparam int CPM  = 24;
  localparam int COLW = CSZ * 16;

  typedef logic [CSZ-1:0][15:0] col_t;

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [4:0] exp_idx;
    logic       exp_last;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH-1:0]        in_valid = '0;
  logic [NCH-1:0]        in_ready;
  logic [NCH-1:0][CSZ-1:0][15:0] in_col;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  col_t                  out_col;
  logic [1:0]            out_ch;
  logic [4:0]            out_col_idx;
  logic                  out_last;
  logic                  map_done;

  int errors = 0;
  int checks = 0;

  relu_column_scheduler #(
    .COLUMN_SIZE (CSZ),
    .NUM_CH      (NCH),
    .COLS_PER_MAP(CPM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_col     (in_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_col    (out_col),
    .out_ch     (out_ch),
    .out_col_idx(out_col_idx),
    .out_last   (out_last),
    .map_done   (map_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [COLW-1:0] act, input logic [COLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic col_t make_col(input int c);
    col_t col;
    for (int j = 0; j < CSZ; j++) begin
      int v;
      v      = ((j * 97 + c * 311) % 2000) - 1000;
      col[j] = 16'(v);
    end
    col[0] = 16'(-5 * (c + 1));
    col[3] = 16'h8000;
    if (c == 0) begin
      col[1] = 16'd0;
      col[2] = 16'd7;
      col[4] = 16'h7fff;
    end
    return col;
  endfunction

  function automatic col_t relu_ref(input col_t col);
    col_t r;
    for (int j = 0; j < CSZ; j++) r[j] = col[j][15] ? 16'd0 : col[j];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[19];

  initial begin
    int accepted;
    int granted;
    int pulses;
    int cyc;
    int exp_ch;
    int mcnt[NCH];
    logic exp_done;

    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 5'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 5'd0, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 5'd0, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 5'd0, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 5'd0, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 5'd0, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 5'd1, 1'b0};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 5'd1, 1'b0};
    tbl[12] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 5'd1, 1'b0};
    tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2, 5'd1, 1'b0};
    tbl[14] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1, 5'd2, 1'b0};
    tbl[15] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3, 5'd1, 1'b0};
    tbl[16] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1, 5'd3, 1'b0};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 5'd2, 1'b0};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 5'd2, 1'b0};

    for (int c = 0; c < NCH; c++) in_col[c] = make_col(c);

    // Reset values, sampled while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_idx", out_col_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_map_done", map_done, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // Vector table: inputs driven at the falling edge, everything checked 1ns later.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("v%0d_out_ch", i), out_ch, tbl[i].exp_ch);
      check($sformatf("v%0d_out_idx", i), out_col_idx, tbl[i].exp_idx);
      check($sformatf("v%0d_out_last", i), out_last, tbl[i].exp_last);
      check($sformatf("v%0d_map_done", i), map_done, 0);
      if (i > 0) check($sformatf("v%0d_out_col", i), out_col, relu_ref(make_col(tbl[i].exp_ch)));
      if (i == 1)
        check("v1_hand_relu", {out_col[4], out_col[3], out_col[2], out_col[1], out_col[0]},
              {16'd32767, 16'd0, 16'd7, 16'd0, 16'd0});
    end

    // Full map with random downstream stalls.
    do_reset();
    accepted = 0;
    granted  = 0;
    pulses   = 0;
    cyc      = 0;
    exp_ch   = 0;
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    while (accepted < NCH * CPM && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (granted < NCH * CPM) ? 4'b1111 : 4'b0000;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (map_done) pulses++;
      if (out_valid && out_ready) begin
        exp_done = (accepted == NCH * CPM - 1);
        check("map_ch", out_ch, exp_ch);
        check("map_idx", out_col_idx, mcnt[exp_ch]);
        check("map_last", out_last, mcnt[exp_ch] == CPM - 1);
        check("map_col", out_col, relu_ref(make_col(exp_ch)));
        check("map_done", map_done, exp_done);
        mcnt[exp_ch] = (mcnt[exp_ch] == CPM - 1) ? 0 : mcnt[exp_ch] + 1;
        exp_ch       = (exp_ch + 1) % NCH;
        accepted++;
      end
      if (|(in_ready & in_valid)) granted++;
    end
    check("map_accept_count", accepted, NCH * CPM);
    check("map_done_pulses", pulses, 1);

    // Counters wrapped: channel 0 restarts at column 0.
    @(negedge clk);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1;
    check("wrap_in_ready", in_ready, 4'b0001);
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    check("wrap_out_valid", out_valid, 1);
    check("wrap_out_ch", out_ch, 0);
    check("wrap_out_idx", out_col_idx, 0);

    // Mid-frame reset with a column held and col_cnt[2] == 10.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid  = 4'b0100;
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_out_idx", out_col_idx, 9);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_idx", out_col_idx, 0);
    check("async_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 4'b0100);
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_out_ch", out_ch, 2);
    check("post_rst_out_idx", out_col_idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
